// File: rtl/normalize_pkg.sv
// Shared types and constants for the leading-zero/leading-one normalizer.
package normalize_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the leading count result (0..32 needs six bits)
  localparam int CNT_W  = 6;
  localparam int NSTEPS = 5;

  // Binary-search window width used at each RUN step
  localparam logic [4:0] STEP_W [NSTEPS] = '{5'd16, 5'd8, 5'd4, 5'd2, 5'd1};

endpackage

// File: rtl/normalize_step.sv
// One binary-search step: if the top w bits of x are all zero, shift x and d
// left by w and add w to the running count. On the last step a residual
// zero MSB means the operand had no terminating bit, so one extra shift
// brings the count to 32 and clears d.
module normalize_step
  import normalize_pkg::*;
(
  input  logic [31:0]      i_x,
  input  logic [31:0]      i_d,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [4:0]       i_w,
  input  logic             i_last,
  output logic [31:0]      o_x,
  output logic [31:0]      o_d,
  output logic [CNT_W-1:0] o_cnt
);

  logic [31:0]      w_mask;
  logic             w_hit;
  logic [31:0]      w_x1;
  logic [31:0]      w_d1;
  logic [CNT_W-1:0] w_cnt1;

  // Window zero test, conditional shift, and the final all-zero correction
  always_comb begin
    w_mask = ~(32'hFFFF_FFFF >> i_w);
    w_hit  = (i_x & w_mask) == 32'd0;
    w_x1   = w_hit ? (i_x << i_w) : i_x;
    w_d1   = w_hit ? (i_d << i_w) : i_d;
    w_cnt1 = w_hit ? (i_cnt + {1'b0, i_w}) : i_cnt;
    o_x    = w_x1;
    o_d    = w_d1;
    o_cnt  = w_cnt1;
    if (i_last && !w_x1[31]) begin
      o_x   = w_x1 << 1;
      o_d   = w_d1 << 1;
      o_cnt = w_cnt1 + 6'd1;
    end
  end

endmodule

// File: rtl/normalize.sv
// Multi-cycle clz/clo counter and normalizer. An accepted start runs five
// binary-search steps (16,8,4,2,1) and then pulses done with count, the
// left-normalized word, and a zero flag for operands with no terminating bit.
module normalize
  import normalize_pkg::*;
(
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [31:0]      data,
  input  logic             ones,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic [31:0]      norm,
  output logic             zero
);

  state_t           r_state;
  logic [31:0]      r_x;
  logic [31:0]      r_d;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_step;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_count;
  logic [31:0]      r_norm;
  logic             r_zero;

  logic [4:0]       w_w;
  logic             w_last;
  logic [31:0]      w_x_nxt;
  logic [31:0]      w_d_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Select the search window width for the current step
  always_comb begin
    w_w = STEP_W[NSTEPS-1];
    for (int k = 0; k < NSTEPS; k++) begin
      if (r_step == 3'(k)) w_w = STEP_W[k];
    end
    w_last = (r_step == 3'(NSTEPS - 1));
  end

  normalize_step u_step (
    .i_x    (r_x),
    .i_d    (r_d),
    .i_cnt  (r_cnt),
    .i_w    (w_w),
    .i_last (w_last),
    .o_x    (w_x_nxt),
    .o_d    (w_d_nxt),
    .o_cnt  (w_cnt_nxt)
  );

  // Control FSM with registered busy/done and result holding registers
  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_x     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_step  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_norm  <= '0;
      r_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (start) begin
            // Counting leading ones is counting leading zeros of ~data
            r_x     <= ones ? ~data : data;
            r_d     <= data;
            r_cnt   <= '0;
            r_step  <= '0;
            r_state <= RUN;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          r_x   <= w_x_nxt;
          r_d   <= w_d_nxt;
          r_cnt <= w_cnt_nxt;
          if (w_last) begin
            r_count <= w_cnt_nxt;
            r_norm  <= w_d_nxt;
            r_zero  <= (w_cnt_nxt == 6'd32);
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_step <= r_step + 3'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy  = r_busy;
  assign done  = r_done;
  assign count = r_count;
  assign norm  = r_norm;
  assign zero  = r_zero;

endmodule

// File: tb/tb_normalize.sv
// Directed bench for normalize: reset state, hand-computed clz/clo vectors,
// start-while-busy, back-to-back, mid-run reset, and bit-pattern sweeps.
module tb_normalize;

  logic        clk;
  logic        clrn;
  logic        start;
  logic [31:0] data;
  logic        ones;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic [31:0] norm;
  logic        zero;

  int n_chk = 0;
  int n_err = 0;

  normalize dut (
    .clk   (clk),
    .clrn  (clrn),
    .start (start),
    .data  (data),
    .ones  (ones),
    .busy  (busy),
    .done  (done),
    .count (count),
    .norm  (norm),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent reference: scan from the MSB for the first terminating bit
  function automatic int ref_count(input logic [31:0] d, input logic o);
    int c = 0;
    for (int i = 31; i >= 0; i--) begin
      if (d[i] != o) break;
      c++;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation (caller sits just after an edge) and wait for done
  task automatic run_op(input string tag, input logic [31:0] d, input logic o,
                        input logic [5:0] e_cnt, input logic [31:0] e_norm,
                        input logic e_zero, input logic chk_lat);
    int lat;
    start = 1'b1;
    data  = d;
    ones  = o;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 20) begin
      if (busy && done) check({tag, "_excl"}, 32'(busy & done), 32'd0);
      tick();
      lat++;
    end
    if (chk_lat) check({tag, "_lat"}, 32'(lat), 32'd6);
    else if (!done) check({tag, "_timeout"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_cnt"},  32'(count), 32'(e_cnt));
    check({tag, "_norm"}, norm, e_norm);
    check({tag, "_zero"}, 32'(zero), 32'(e_zero));
  endtask

  task automatic run_ref(input string tag, input logic [31:0] d, input logic o);
    int c;
    logic [31:0] n;
    c = ref_count(d, o);
    n = (c == 32) ? 32'd0 : (d << c);
    run_op(tag, d, o, 6'(c), n, (c == 32), 1'b0);
  endtask

  initial begin
    int lat;
    logic [31:0] v;
    clrn  = 1'b0;
    start = 1'b0;
    data  = '0;
    ones  = 1'b0;
    tick();
    tick();
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_norm",  norm,       32'd0);
    check("rst_zero",  32'(zero),  32'd0);
    clrn = 1'b1;
    tick();

    // Hand-computed directed vectors
    run_op("clz_16",    32'h0001_0000, 1'b0, 6'd15, 32'h8000_0000, 1'b0, 1'b1);
    tick();
    run_op("clz_zero",  32'h0000_0000, 1'b0, 6'd32, 32'h0000_0000, 1'b1, 1'b1);
    tick();
    run_op("clz_msb",   32'h8000_0000, 1'b0, 6'd0,  32'h8000_0000, 1'b0, 1'b1);
    tick();
    run_op("clo_16",    32'hFFFF_0F00, 1'b1, 6'd16, 32'h0F00_0000, 1'b0, 1'b1);
    tick();
    run_op("clo_all",   32'hFFFF_FFFF, 1'b1, 6'd32, 32'h0000_0000, 1'b1, 1'b1);
    tick();

    // start pulsed mid-run must be ignored
    start = 1'b1;
    data  = 32'h0001_0000;
    ones  = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    data  = 32'h0000_0001;
    tick();
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    lat = 3;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("ign_lat",  32'(lat),   32'd6);
    check("ign_cnt",  32'(count), 32'd15);
    check("ign_norm", norm,       32'h8000_0000);

    // Back-to-back start while in DONE
    start = 1'b1;
    data  = 32'h0000_0001;
    ones  = 1'b0;
    tick();
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done", 32'(done), 32'd0);
    lat = 1;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b_lat",  32'(lat),   32'd6);
    check("b2b_cnt",  32'(count), 32'd31);
    check("b2b_norm", norm,       32'h8000_0000);
    tick();

    // Reset during RUN step 2 aborts the operation
    start = 1'b1;
    data  = 32'h00F0_0000;
    tick();
    start = 1'b0;
    tick();
    tick();
    clrn = 1'b0;
    tick();
    check("mrst_busy",  32'(busy),  32'd0);
    check("mrst_done",  32'(done),  32'd0);
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_norm",  norm,       32'd0);
    clrn = 1'b1;
    tick();
    check("mrst_nodone", 32'(done), 32'd0);
    run_op("fresh", 32'h00F0_0000, 1'b0, 6'd8, 32'hF000_0000, 1'b0, 1'b1);
    tick();

    // Single-bit and all-ones-prefix sweeps against the scan model
    for (int b = 0; b < 32; b++) begin
      v = 32'd1 << b;
      run_ref($sformatf("bit%0d", b), v, 1'b0);
      run_ref($sformatf("nbit%0d", b), ~v, 1'b1);
    end
    for (int n = 0; n <= 32; n++) begin
      v = (n == 32) ? 32'hFFFF_FFFF : ~(32'hFFFF_FFFF >> n);
      run_ref($sformatf("pfx%0d", n), v, 1'b1);
      run_ref($sformatf("zpfx%0d", n), ~v, 1'b0);
    end
    for (int r = 0; r < 200; r++) begin
      v = $urandom >> $urandom_range(0, 31);
      run_ref($sformatf("rnd%0d", r), (r % 2 == 1) ? ~v : v, 1'(r % 2));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/normalize.md
# normalize

Multi-cycle leading-zero/leading-one counter and normalizer for the integer datapath. It is the inverse companion of the barrel shifter: the shifter applies a shift amount, while this block derives one. Given a 32-bit word, it returns the leading-zero count (clz) or leading-one count (clo) and the word left-shifted by that count. It sits beside the ALU, serves clz/clo and software normalization sequences, and uses a start/done handshake with fixed 6-cycle latency.

## Interface
Parameters: none (32-bit datapath fixed).
- clk  in  1  clock; all state changes on rising edge
- clrn  in  1  reset, synchronous, active-low
- start  in  1  request; sampled only when block is idle or in DONE
- data  in  32  operand; sampled with accepted start
- ones  in  1  1: count leading ones (clo); 0: count leading zeros (clz); sampled with start
- busy  out  1  high while computing (RUN)
- done  out  1  one-cycle pulse; results valid from this cycle until next done
- count  out  6  leading count, 0..32
- norm  out  32  data << count (logical); 0 when count = 32
- zero  out  1  operand had no terminating bit (clz: data==0; clo: data==0xFFFFFFFF), i.e. count==32

## Operation
- States: IDLE, RUN (5 steps, step index 0..4), DONE.
- Accept (IDLE or DONE, start=1): x <= ones ? ~data : data; d <= data; cnt <= 0; step <= 0; go to RUN.
- RUN step k uses width w = 16 >> k (16, 8, 4, 2, 1). If x[31:32-w] == 0, then x <= x << w, d <= d << w, cnt <= cnt + w.
- On step 4, after the w=1 test, if the resulting x[31] is still 0, apply one more shift of 1 to x and d, and add 1 to cnt. This is the only path to count = 32 and norm = 0.
- After step 4: register count <= cnt, norm <= d, zero <= (cnt == 32); go to DONE.
- DONE: done=1 for one cycle. With start=1, the block accepts a new operation (back-to-back); otherwise it returns to IDLE.
- start during RUN is ignored; no queuing.
- count, norm and zero hold their values between completions and change only at the RUN->DONE transition.
- All arithmetic is unsigned. cnt is 6 bits and cannot overflow (maximum 16+8+4+2+1+1 = 32).

## Timing
- Reset (clrn=0 at an edge): state=IDLE, busy=0, done=0, count=0, norm=0, zero=0, internal x/d/cnt cleared.
- Reset mid-RUN aborts the operation; there is no done pulse for it. start is honoured on the first edge with clrn=1.
- Latency: start accepted at edge E0. busy=1 after edges E0..E4 (5 cycles). done=1 after E5, with results valid in the same cycle.
- Throughput: one result every 6 cycles with back-to-back start in DONE.
- busy and done are never high together. Outputs are fully registered and there is no combinational input-to-output path.

## Structure
- Shared package normalize_pkg: state enum (IDLE, RUN, DONE), step-width constant array {16,8,4,2,1}, result width constant (6).
- Optional sub-module norm_step: combinational width-w zero test plus conditional shift of x/d and count increment. The FSM instantiates it once, with w selected by step.
- The counting algorithm needs no instance of the existing shifter.

## Test plan
- clz data=0x00010000 -> done exactly 6 cycles after start, count=15, norm=0x80000000, zero=0.
- clz data=0x00000000 -> count=32, norm=0x00000000, zero=1; clz data=0x80000000 -> count=0, norm=0x80000000.
- clo ones=1 data=0xFFFF0F00 -> count=16, norm=0x0F000000; clo data=0xFFFFFFFF -> count=32, norm=0, zero=1.
- start pulsed during busy with data=0x1 -> ignored, first result unchanged. Back-to-back start in DONE with clz 0x00000001 -> second done 6 cycles later, count=31, norm=0x80000000.
- clrn=0 at RUN step 2 -> next cycle busy=0, done=0, count=0, norm=0. A fresh clz 0x00F00000 completes with count=8, norm=0xF0000000.
- Random sweep against reference model (clz/clo, norm = data<<count): count, norm and zero match for 10k operands, including all single-bit and all-ones-prefix patterns.
